focal_maxpool_ctrl: RTL and testbench
=====================================

# focal_maxpool_ctrl

Streaming controller that drives the 2x2 focal max-pool datapath (`FocalMaxPoolRow` row-pair max stage plus a final 2-input max). It accepts a raster of 4-bit cells one per cycle in row-major order and buffers each even row in a line buffer. On each odd row it presents the 2x2 window (A,B from the buffer, C,D from the stream) to the datapath and emits one pooled 4-bit cell per window. It sits between the cell input stream and the tinyspu output mux, and is the block that sequences the max-pool operation per frame.

## Interface

Parameters:
- `W`, 8, raster width in cells; even, ≥2
- `H`, 8, raster height in rows; even, ≥2

Ports:
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  arms one frame; honoured only in IDLE
- `in_cell`  in  4  input raster cell
- `in_valid`  in  1  `in_cell` valid
- `in_ready`  out  1  controller accepts `in_cell` this cycle
- `out_cell`  out  4  pooled cell, max of the 2x2 window
- `out_valid`  out  1  `out_cell` valid
- `out_ready`  in  1  downstream accepts `out_cell`
- `busy`  out  1  high in FILL or POOL
- `frame_done`  out  1  one-cycle pulse when the last pooled cell is loaded

## Operation

- A beat is accepted when `in_valid && in_ready`. The state machine and the counters advance only on accepted beats.
- States:
  - IDLE: `in_ready`=0. `start` moves to FILL and clears `col`=0 and `row`=0.
  - FILL (even row): each beat writes `linebuf[col]`=`in_cell`. On `col`==W-1, `col` wraps to 0, `row` increments, and the state moves to POOL.
  - POOL (odd row):
    - Even `col`: latch `in_cell` into `hold_c`.
    - Odd `col`: drive A=`linebuf[col-1]`, B=`linebuf[col]`, C=`hold_c`, D=`in_cell`. Register `out_cell`=max(M,N) and set `out_valid`=1.
    - On `col`==W-1, `col` wraps to 0 and `row` increments. If the old `row`==H-1, go to IDLE and pulse `frame_done`; otherwise go to FILL.
- `in_ready` = (state≠IDLE) && !(`out_valid` && !`out_ready`). The controller stalls all input, in every row, while a pooled cell is pending.
- `out_valid` clears on `out_ready` unless a new pooled cell is loaded in the same cycle, in which case it stays 1 with the new value.
- Comparison is unsigned 4-bit. Ties select either operand (values are equal). No arithmetic overflow is possible.
- Counter widths are `$clog2(W)` and `$clog2(H)`. Counters wrap exactly at W-1 and H-1 and never index outside `linebuf`.
- Output per frame: (W/2)·(H/2) pooled cells in raster order.
- `start` outside IDLE is ignored. A `start` in the same cycle as the IDLE transition is ignored too; the frame must be re-armed.
- `in_valid` in IDLE is ignored and no data is consumed.

## Timing

- Reset values: state=IDLE, `col`=0, `row`=0, `in_ready`=0, `out_valid`=0, `out_cell`=0, `busy`=0, `frame_done`=0, `hold_c`=0. `linebuf` is not reset.
- Latency: the D beat is accepted in cycle t; `out_valid`/`out_cell` are valid in cycle t+1.
- Throughput: 1 input cell per cycle when `out_ready` is held high.
- `frame_done` is asserted in cycle t+1, coincident with `out_valid` rising for the final cell.
- `busy` falls in the same cycle `frame_done` rises.
- `rst` mid-frame: on the next edge, all state returns to reset values. Any pending `out_cell` is dropped and no `frame_done` pulse is generated.

## Structure

- Shared package `tinyspu_pkg`: `CELL_W`=4 and the state enum `fmp_state_t` {IDLE, FILL, POOL}.
- Sub-module: one `FocalMaxPoolRow` instance provides M and N. The final max(M,N) is a single comparator in the controller.
- `linebuf`: W×4 flops. No RAM macro.

## Test plan

- Basic pooling, W=4, H=2: row0 = 1,7,3,2; row1 = 5,0,9,4, `out_ready`=1. Required: `out_cell` = 7 then 9; `frame_done` pulses with the 9; then IDLE with `in_ready`=0.
- Extremes, W=4, H=4: an all-15 frame gives four outputs of 15. An all-0 frame gives four outputs of 0. Row0 = 0,0,0,0 with row1 = 0,15,0,0 gives 15 for the first window.
- Backpressure: `out_ready`=0 for 3 cycles after the first pooled cell. Required: `in_ready`=0 during the stall, `out_cell` stable, no beats lost. Final outputs match the no-stall run.
- Bubbles: `in_valid` toggles every other cycle. Required: outputs are identical to the continuous-stream run; the counters advance only on accepted beats.
- Mid-frame reset: assert `rst` during POOL at `col`=1, then `start` and send a fresh frame. Required: no stale output, correct pooled results, exactly one `frame_done`.
- Start handling: `start` pulsed while `busy` is ignored, and the frame completes normally. `in_valid`=1 in IDLE produces `in_ready`=0 and no output.

Source files
------------

// File: rtl/tinyspu_pkg.sv
// Shared tinyspu definitions: cell width, max-pool controller states,
// and the unsigned cell maximum used by the pooling datapath.
package tinyspu_pkg;

  localparam int CELL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    POOL = 2'd2
  } fmp_state_t;

  // Unsigned maximum of two cells; on a tie either operand is the same value.
  function automatic logic [CELL_W-1:0] cell_max(
    input logic [CELL_W-1:0] x,
    input logic [CELL_W-1:0] y
  );
    return (x >= y) ? x : y;
  endfunction

endpackage

// File: rtl/focal_maxpool_ctrl_row.sv
// Row-pair max stage of the 2x2 focal max-pool: M is the max of the
// buffered (upper) pair, N is the max of the streamed (lower) pair.
module FocalMaxPoolRow
  import tinyspu_pkg::*;
(
  input  logic [CELL_W-1:0] a,
  input  logic [CELL_W-1:0] b,
  input  logic [CELL_W-1:0] c,
  input  logic [CELL_W-1:0] d,
  output logic [CELL_W-1:0] m,
  output logic [CELL_W-1:0] n
);

  assign m = cell_max(a, b);
  assign n = cell_max(c, d);

endmodule

// File: rtl/focal_maxpool_ctrl.sv
// Streaming 2x2 max-pool controller. Even rows are captured into a line
// buffer; on odd rows each pair of streamed cells is combined with the
// buffered pair above it and one pooled cell is emitted per window.
module focal_maxpool_ctrl
  import tinyspu_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CELL_W-1:0] in_cell,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CELL_W-1:0] out_cell,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  fmp_state_t        state_r;
  logic [CW-1:0]     col_r;
  logic [RW-1:0]     row_r;
  logic [CELL_W-1:0] linebuf_r [W];
  logic [CELL_W-1:0] hold_c_r;
  logic [CELL_W-1:0] out_cell_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              frame_done_r;

  logic              in_ready_s;
  logic              accept_s;
  logic [CW-1:0]     col_a_s;
  logic [CELL_W-1:0] m_s;
  logic [CELL_W-1:0] n_s;
  logic [CELL_W-1:0] pooled_s;

  // Input is stalled whenever a pooled cell is waiting, so a window can
  // never be completed while its predecessor is still unconsumed.
  assign in_ready_s = (state_r != IDLE) && !(out_valid_r && !out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign col_a_s    = col_r - CW'(1);

  FocalMaxPoolRow u_row (
    .a (linebuf_r[col_a_s]),
    .b (linebuf_r[col_r]),
    .c (hold_c_r),
    .d (in_cell),
    .m (m_s),
    .n (n_s)
  );

  assign pooled_s = (m_s >= n_s) ? m_s : n_s;

  assign in_ready   = in_ready_s;
  assign out_cell   = out_cell_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Line buffer capture of the even row; deliberately left without reset.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == FILL) && accept_s) begin
      linebuf_r[col_r] <= in_cell;
    end
  end

  // Frame sequencing FSM with counters and registered output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      col_r        <= '0;
      row_r        <= '0;
      hold_c_r     <= '0;
      out_cell_r   <= '0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= FILL;
            col_r   <= '0;
            row_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        FILL: begin
          if (accept_s) begin
            if (col_r == COL_LAST) begin
              col_r   <= '0;
              row_r   <= row_r + RW'(1);
              state_r <= POOL;
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        POOL: begin
          if (accept_s) begin
            if (!col_r[0]) begin
              hold_c_r <= in_cell;
            end else begin
              out_cell_r  <= pooled_s;
              out_valid_r <= 1'b1;
            end
            if (col_r == COL_LAST) begin
              col_r <= '0;
              if (row_r == ROW_LAST) begin
                row_r        <= '0;
                state_r      <= IDLE;
                busy_r       <= 1'b0;
                frame_done_r <= 1'b1;
              end else begin
                row_r   <= row_r + RW'(1);
                state_r <= FILL;
              end
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_focal_maxpool_ctrl.sv
// Randomized bench for focal_maxpool_ctrl: a 4x4 instance and a 4x2 instance
// share the input stimulus; a select bit picks which one is armed and observed.
module tb_focal_maxpool_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [3:0] in_cell;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, busy_a, frame_done_a;
  logic [3:0] out_cell_a;
  logic       in_ready_b, out_valid_b, busy_b, frame_done_b;
  logic [3:0] out_cell_b;

  logic       in_ready, out_valid, busy, frame_done;
  logic [3:0] out_cell;

  int total = 0;
  int bad   = 0;
  logic [3:0] frm [16];

  always #5 clk = ~clk;

  focal_maxpool_ctrl #(.W(4), .H(4)) u_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .in_cell(in_cell),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_cell(out_cell_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a),
    .frame_done(frame_done_a)
  );

  focal_maxpool_ctrl #(.W(4), .H(2)) u_b (
    .clk(clk), .rst(rst), .start(start & sel), .in_cell(in_cell),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_cell(out_cell_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b),
    .frame_done(frame_done_b)
  );

  assign in_ready   = sel ? in_ready_b   : in_ready_a;
  assign out_valid  = sel ? out_valid_b  : out_valid_a;
  assign out_cell   = sel ? out_cell_b   : out_cell_a;
  assign busy       = sel ? busy_b       : busy_a;
  assign frame_done = sel ? frame_done_b : frame_done_a;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: each output is the max of a 2x2 block of the frame, raster order.
  task automatic build_expected(input int rows, output int exp_q [$]);
    exp_q = {};
    for (int r = 0; r < rows; r += 2) begin
      for (int c = 0; c < 4; c += 2) begin
        int mx = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (int'(frm[(r + dr) * 4 + c + dc]) > mx) mx = int'(frm[(r + dr) * 4 + c + dc]);
        exp_q.push_back(mx);
      end
    end
  endtask

  // bubble: 0 continuous, 1 every other cycle, 2 random
  // stall: 0 always ready, 1 random, 2 three-cycle stall after first output
  task automatic run_frame(input int rows, input int bubble, input int stall, input bit poke_start);
    int exp_q [$];
    int got [$];
    int nin = rows * 4;
    int nout = rows;
    int idx = 0;
    int cyc = 0;
    int fd = 0;
    int stall_left = 0;
    int lat_exp = 0;
    bit lat_pend = 1'b0;
    bit first_seen = 1'b0;
    bit prev_hold = 1'b0;
    logic [3:0] prev_cell = 4'd0;
    build_expected(rows, exp_q);

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check_val("busy_after_start", int'(busy), 1);

    while ((idx < nin || got.size() < nout) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      case (bubble)
        0: in_valid = (idx < nin);
        1: in_valid = (idx < nin) && (cyc % 2 == 0);
        default: in_valid = (idx < nin) && ($urandom_range(0, 1) == 1);
      endcase
      in_cell = (idx < nin) ? frm[idx] : 4'($urandom_range(0, 15));
      if (stall == 2) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end else if (stall == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      start = poke_start && (cyc == 6);
      #1;
      if (lat_pend) begin
        check_val("latency_valid", int'(out_valid), 1);
        check_val("latency_cell", int'(out_cell), lat_exp);
        lat_pend = 1'b0;
      end
      if (stall == 2 && out_valid && !first_seen) begin
        first_seen = 1'b1;
        out_ready = 1'b0;
        stall_left = 2;
        #1;
      end
      if (out_valid && !out_ready) check_val("stall_in_ready", int'(in_ready), 0);
      if (prev_hold && out_valid) check_val("stall_hold_cell", int'(out_cell), int'(prev_cell));
      prev_hold = out_valid && !out_ready;
      prev_cell = out_cell;
      if (frame_done) begin
        fd++;
        check_val("done_with_valid", int'(out_valid), 1);
        check_val("done_busy_low", int'(busy), 0);
        check_val("done_is_last", got.size() + 1, nout);
      end
      if (out_valid && out_ready) got.push_back(int'(out_cell));
      if (in_valid && in_ready) begin
        if (((idx / 4) % 2 == 1) && ((idx % 4) % 2 == 1)) begin
          lat_pend = 1'b1;
          lat_exp = exp_q[((idx / 4) / 2) * 2 + (idx % 4) / 2];
        end
        idx++;
      end
    end
    start = 1'b0;
    check_val("frame_timeout", int'(cyc < 400), 1);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (frame_done) fd++;
      if (out_valid) got.push_back(int'(out_cell));
    end

    check_val("out_count", got.size(), nout);
    for (int i = 0; i < nout; i++)
      check_val("pooled_cell", (i < got.size()) ? got[i] : -1, exp_q[i]);
    check_val("done_count", fd, 1);
    check_val("idle_in_ready", int'(in_ready), 0);
    check_val("idle_busy", int'(busy), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_in_ready"}, int'(in_ready), 0);
    check_val({tag, "_out_valid"}, int'(out_valid), 0);
    check_val({tag, "_out_cell"}, int'(out_cell), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) frm[i] = 4'($urandom_range(0, 15));
  endtask

  // Accept row 0 and the first cell of row 1, then reset while in POOL at col 1.
  task automatic mid_reset();
    int k = 0;
    int guard = 0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < 5 && guard < 50) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b1;
      in_cell = 4'($urandom_range(0, 15));
      #1;
      if (in_ready) k++;
    end
    check_val("midrst_feed_timeout", k, 5);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_values("midrst");
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_cell = 4'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_reset_values("reset_a");
    sel = 1'b1;
    #1 check_reset_values("reset_b");
    @(negedge clk);
    rst = 1'b0;

    // basic 4x2 pooling
    sel = 1'b1;
    frm[0] = 4'd1; frm[1] = 4'd7; frm[2] = 4'd3; frm[3] = 4'd2;
    frm[4] = 4'd5; frm[5] = 4'd0; frm[6] = 4'd9; frm[7] = 4'd4;
    run_frame(2, 0, 0, 1'b0);

    // extremes on 4x4
    sel = 1'b0;
    for (int i = 0; i < 16; i++) frm[i] = 4'd15;
    run_frame(4, 0, 0, 1'b0);
    for (int i = 0; i < 16; i++) frm[i] = 4'd0;
    run_frame(4, 0, 0, 1'b0);
    rand_frame();
    for (int i = 0; i < 8; i++) frm[i] = 4'd0;
    frm[5] = 4'd15;
    run_frame(4, 0, 0, 1'b0);

    // one random frame under plain, stalled and bubbled streams
    rand_frame();
    run_frame(4, 0, 0, 1'b0);
    run_frame(4, 0, 2, 1'b0);
    run_frame(4, 1, 0, 1'b0);

    // random frames with random bubbles and backpressure
    for (int f = 0; f < 6; f++) begin
      rand_frame();
      run_frame(4, 2, 1, 1'b0);
    end

    // start while busy is ignored
    rand_frame();
    run_frame(4, 0, 0, 1'b1);

    // mid-frame reset then a fresh frame
    mid_reset();
    rand_frame();
    run_frame(4, 2, 1, 1'b0);

    // in_valid in IDLE consumes nothing
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_cell = 4'($urandom_range(0, 15)); out_ready = 1'b1;
      #1;
      check_val("idle_valid_in_ready", int'(in_ready), 0);
      check_val("idle_valid_out_valid", int'(out_valid), 0);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
